// File: rtl/pp_pkg.sv
// Shared constants, state encoding and lane slicing for the partial-product streamer.
`ifndef PP_PKG_SV
`define PP_PKG_SV
`define PP_LANE(k, w) (k)*2*(w) +: 2*(w)

package pp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic int npp(input int w);
    return w + 1;
  endfunction

  function automatic int beats(input int w, input int lanes);
    return (npp(w) + lanes - 1) / lanes;
  endfunction

  // Row indices seen by a lane reach at most 2W once padding lanes are counted.
  function automatic int rowidx_w(input int w);
    return $clog2(2 * w + 1);
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`endif

// File: rtl/pp_stream_gen_if.sv
// Operand-in / partial-product-out handshake bundle for pp_stream_gen.
interface pp_stream_gen_if #(
  parameter int W     = 32,
  parameter int LANES = 4
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic [W-1:0]                 x;
  logic [W-1:0]                 y;
  logic                         is_signed;
  logic                         pp_valid;
  logic                         pp_ready;
  logic [LANES*2*W-1:0]         pp_data;
  logic [$clog2(W+1)-1:0]       pp_index;
  logic                         pp_last;

  modport master (
    output in_valid, x, y, is_signed, pp_ready,
    input  in_ready, pp_valid, pp_data, pp_index, pp_last
  );

  modport slave (
    input  in_valid, x, y, is_signed, pp_ready,
    output in_ready, pp_valid, pp_data, pp_index, pp_last
  );
endinterface

// File: rtl/pp_row_gen.sv
// One Baugh-Wooley style partial-product row, 2W bits, selected by row index.
module pp_row_gen
  import pp_pkg::*;
#(
  parameter int W   = 32,
  parameter int RIW = rowidx_w(W)
) (
  input  logic [W-1:0]   x_q,
  input  logic [W-1:0]   y_q,
  input  logic           m_q,
  input  logic [RIW-1:0] row,
  output logic [2*W-1:0] row_val
);
  localparam int SW = $clog2(W);
  localparam logic [RIW-1:0] ROW_MSB  = RIW'(W - 1);
  localparam logic [RIW-1:0] ROW_CORR = RIW'(W);

  logic [2*W-1:0] ext_y;
  logic [2*W-1:0] ext_ny;
  logic [SW-1:0]  sel;

  assign ext_y  = m_q ? {{W{y_q[W-1]}}, y_q} : {{W{1'b0}}, y_q};
  assign ext_ny = {{W{~y_q[W-1]}}, ~y_q};
  assign sel    = row[SW-1:0];

  // The sign row uses ~y and the correction row supplies the +1 of -y at weight 2^(W-1).
  always_comb begin
    row_val = '0;
    if (row < ROW_MSB) begin
      if (x_q[sel]) row_val = ext_y << row;
    end else if (row == ROW_MSB) begin
      if (x_q[W-1]) row_val = (m_q ? ext_ny : ext_y) << (W - 1);
    end else if (row == ROW_CORR) begin
      if (m_q && x_q[W-1]) row_val = (2*W)'(1) << (W - 1);
    end
  end
endmodule

// File: rtl/pp_stream_gen.sv
// Captures an operand pair and streams its W+1 partial products LANES rows per beat.
module pp_stream_gen
  import pp_pkg::*;
#(
  parameter int W     = 32,
  parameter int LANES = 4
) (
  input logic            clk,
  input logic            rst_n,
  pp_stream_gen_if.slave bus
);
  localparam int BEATS = beats(W, LANES);
  localparam int BW    = cnt_w(BEATS);
  localparam int IW    = $clog2(W + 1);
  localparam int RIW   = rowidx_w(W);
  localparam logic [BW-1:0] B_LAST = BW'(BEATS - 1);

  state_e               state;
  logic [BW-1:0]        b;
  logic [W-1:0]         x_q;
  logic [W-1:0]         y_q;
  logic                 m_q;
  logic                 emit;
  logic                 last;
  logic [IW-1:0]        idx;
  logic [2*W-1:0]       lanes [LANES];
  logic [LANES*2*W-1:0] data_w;

  assign emit = (state == EMIT);
  assign last = emit && (b == B_LAST);
  assign idx  = IW'(int'(b) * LANES);

  assign bus.pp_valid = emit;
  assign bus.pp_last  = last;
  assign bus.pp_index = idx;
  assign bus.pp_data  = data_w;
  // pp_ready -> in_ready is the one combinational path, enabling zero-bubble chaining.
  assign bus.in_ready = rst_n && (!emit || (bus.pp_ready && last));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      b     <= '0;
      x_q   <= '0;
      y_q   <= '0;
      m_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_q   <= bus.x;
            y_q   <= bus.y;
            m_q   <= bus.is_signed;
            b     <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (bus.pp_ready) begin
            if (b != B_LAST) begin
              b <= b + 1'b1;
            end else if (bus.in_valid) begin
              x_q <= bus.x;
              y_q <= bus.y;
              m_q <= bus.is_signed;
              b   <= '0;
            end else begin
              b     <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [RIW-1:0] row;
    logic [2*W-1:0] row_val;

    assign row = RIW'(idx) + RIW'(k);

    pp_row_gen #(.W(W)) u_row (
      .x_q     (x_q),
      .y_q     (y_q),
      .m_q     (m_q),
      .row     (row),
      .row_val (row_val)
    );

    assign lanes[k] = emit ? row_val : '0;
  end

  always_comb begin
    data_w = '0;
    for (int k = 0; k < LANES; k++) data_w[`PP_LANE(k, W)] = lanes[k];
  end
endmodule

// File: tb/tb_pp_stream_gen.sv
// Directed-vector and randomized-sum bench for pp_stream_gen at W=32/LANES=4 and W=8/LANES=9.
module tb_pp_stream_gen;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pp_stream_gen_if #(.W(32), .LANES(4)) if32 ();
  pp_stream_gen_if #(.W(8),  .LANES(9)) if8 ();

  pp_stream_gen #(.W(32), .LANES(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
  pp_stream_gen #(.W(8),  .LANES(9)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        m;
    int          ra;
    logic [63:0] va;
    int          rb;
    logic [63:0] vb;
    int          rc;
    logic [63:0] vc;
    int          nz;
    logic [63:0] sum;
  } vec_t;

  vec_t        vecs [6];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] rows32 [36];
  logic [15:0] rows8 [9];
  logic [63:0] stall_exp [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [63:0] prod32(input logic [31:0] a, input logic [31:0] c, input logic m);
    if (m) return {{32{a[31]}}, a} * {{32{c[31]}}, c};
    return {32'b0, a} * {32'b0, c};
  endfunction

  function automatic logic [15:0] prod8(input logic [7:0] a, input logic [7:0] c, input logic m);
    if (m) return {{8{a[7]}}, a} * {{8{c[7]}}, c};
    return {8'b0, a} * {8'b0, c};
  endfunction

  function automatic logic [63:0] sum32();
    logic [63:0] s = '0;
    for (int i = 0; i < 36; i++) s += rows32[i];
    return s;
  endfunction

  function automatic int nz32();
    int n = 0;
    for (int i = 0; i < 33; i++) if (rows32[i] != 64'd0) n++;
    return n;
  endfunction

  function automatic logic [15:0] sum8();
    logic [15:0] s = '0;
    for (int i = 0; i < 9; i++) s += rows8[i];
    return s;
  endfunction

  task automatic accept32(input logic [31:0] ax, input logic [31:0] ay, input logic am);
    if32.in_valid = 1'b1; if32.x = ax; if32.y = ay; if32.is_signed = am; if32.pp_ready = 1'b1;
    #2;
    chk("accept32_in_ready", 64'(if32.in_ready), 64'd1);
    @(posedge clk); #1;
    if32.in_valid = 1'b0; if32.x = $urandom; if32.y = $urandom; if32.is_signed = ~am;
  endtask

  task automatic beats32(input logic [31:0] nx, input logic [31:0] ny, input logic nm,
                         input bit chain, input int stall_at, input int rst_at);
    for (int b = 0; b < 9; b++) begin
      if (b == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          if32.pp_ready = 1'b0;
          if32.in_valid = (s == 2);
          if (s == 2) begin if32.x = 32'd5; if32.y = 32'd3; if32.is_signed = 1'b0; end
          #2;
          chk("stall_valid", 64'(if32.pp_valid), 64'd1);
          chk("stall_index", 64'(if32.pp_index), 64'(b * 4));
          chk("stall_in_ready", 64'(if32.in_ready), 64'd0);
          for (int k = 0; k < 4; k++) chk("stall_lane", if32.pp_data[k*64 +: 64], stall_exp[k]);
          @(posedge clk); #1;
        end
        if32.in_valid = 1'b0;
      end
      if (b == rst_at) begin
        rst_n = 1'b0; if32.pp_ready = 1'b1;
        #2;
        chk("rst_in_ready_low", 64'(if32.in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_valid", 64'(if32.pp_valid), 64'd0);
        chk("post_rst_in_ready", 64'(if32.in_ready), 64'd1);
        chk("post_rst_index", 64'(if32.pp_index), 64'd0);
        chk("post_rst_data", 64'(|if32.pp_data), 64'd0);
        return;
      end
      if32.pp_ready = 1'b1;
      if (b == 8 && chain) begin
        if32.in_valid = 1'b1; if32.x = nx; if32.y = ny; if32.is_signed = nm;
      end
      #2;
      chk("beat_valid", 64'(if32.pp_valid), 64'd1);
      chk("beat_index", 64'(if32.pp_index), 64'(b * 4));
      chk("beat_last", 64'(if32.pp_last), 64'(b == 8));
      for (int k = 0; k < 4; k++) rows32[b*4 + k] = if32.pp_data[k*64 +: 64];
      if (b == 8 && chain) chk("b2b_in_ready", 64'(if32.in_ready), 64'd1);
      @(posedge clk); #1;
      if32.in_valid = 1'b0;
    end
  endtask

  task automatic accept8(input logic [7:0] ax, input logic [7:0] ay, input logic am);
    if8.in_valid = 1'b1; if8.x = ax; if8.y = ay; if8.is_signed = am; if8.pp_ready = 1'b1;
    #2;
    chk("accept8_in_ready", 64'(if8.in_ready), 64'd1);
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if8.x = 8'($urandom); if8.y = 8'($urandom); if8.is_signed = ~am;
  endtask

  task automatic beat8(input logic [7:0] nx, input logic [7:0] ny, input logic nm, input bit chain);
    if8.pp_ready = 1'b1;
    if (chain) begin if8.in_valid = 1'b1; if8.x = nx; if8.y = ny; if8.is_signed = nm; end
    #2;
    chk("w8_valid", 64'(if8.pp_valid), 64'd1);
    chk("w8_index", 64'(if8.pp_index), 64'd0);
    chk("w8_last", 64'(if8.pp_last), 64'd1);
    if (chain) chk("w8_b2b_in_ready", 64'(if8.in_ready), 64'd1);
    for (int k = 0; k < 9; k++) rows8[k] = if8.pp_data[k*16 +: 16];
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] cx, cy, nx, ny;
    logic        cm, nm;
    logic [7:0]  ax, ay, bx, by;
    logic        am, bm;
    bit          ch;

    vecs[0] = '{32'd5, 32'd3, 1'b0, 0, 64'd3, 2, 64'hC, 32, 64'd0, 2, 64'd15};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 31, 64'd0, 32, 64'h80000000, 0, 64'hFFFFFFFFFFFFFFFF, 32, 64'd1};
    vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 31, 64'hC000000000000000, 32, 64'h80000000, 0, 64'd0, 2, 64'hC000000080000000};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 31, 64'h7FFFFFFF80000000, 32, 64'd0, 1, 64'h1FFFFFFFE, 32, 64'hFFFFFFFE00000001};
    vecs[4] = '{32'd3, 32'hFFFFFFFE, 1'b1, 0, 64'hFFFFFFFFFFFFFFFE, 1, 64'hFFFFFFFFFFFFFFFC, 32, 64'd0, 2, 64'hFFFFFFFFFFFFFFFA};
    vecs[5] = '{32'd0, 32'h12345678, 1'b0, 0, 64'd0, 31, 64'd0, 32, 64'd0, 0, 64'd0};

    rst_n = 1'b0;
    if32.in_valid = 1'b0; if32.x = '0; if32.y = '0; if32.is_signed = 1'b0; if32.pp_ready = 1'b0;
    if8.in_valid = 1'b0; if8.x = '0; if8.y = '0; if8.is_signed = 1'b0; if8.pp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(if32.pp_valid), 64'd0);
    chk("reset_in_ready", 64'(if32.in_ready), 64'd0);
    chk("reset_index", 64'(if32.pp_index), 64'd0);
    chk("reset_last", 64'(if32.pp_last), 64'd0);
    chk("reset_data", 64'(|if32.pp_data), 64'd0);
    chk("reset_w8_valid", 64'(if8.pp_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", 64'(if32.in_ready), 64'd1);
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      accept32(vecs[v].x, vecs[v].y, vecs[v].m);
      beats32('0, '0, 1'b0, 1'b0, -1, -1);
      chk($sformatf("vec%0d_sum", v), sum32(), vecs[v].sum);
      chk($sformatf("vec%0d_row%0d", v, vecs[v].ra), rows32[vecs[v].ra], vecs[v].va);
      chk($sformatf("vec%0d_row%0d", v, vecs[v].rb), rows32[vecs[v].rb], vecs[v].vb);
      chk($sformatf("vec%0d_row%0d", v, vecs[v].rc), rows32[vecs[v].rc], vecs[v].vc);
      chk($sformatf("vec%0d_nonzero_rows", v), 64'(nz32()), 64'(vecs[v].nz));
      chk($sformatf("vec%0d_padding", v), rows32[33] | rows32[34] | rows32[35], 64'd0);
      chk($sformatf("vec%0d_idle_after", v), 64'(if32.pp_valid), 64'd0);
    end

    // Stall at beat 3 with an in_valid pulse that must be ignored.
    for (int k = 0; k < 4; k++) stall_exp[k] = 64'd3 << (12 + k);
    accept32(32'hFFFFFFFF, 32'd3, 1'b0);
    beats32('0, '0, 1'b0, 1'b0, 3, -1);
    chk("stall_sum", sum32(), 64'h2FFFFFFFD);
    chk("stall_no_capture", 64'(if32.pp_valid), 64'd0);

    // Back-to-back: op2 offered during op1's last beat.
    accept32(32'd5, 32'd3, 1'b0);
    beats32(32'd7, 32'd9, 1'b0, 1'b1, -1, -1);
    chk("b2b_op1_sum", sum32(), 64'd15);
    beats32('0, '0, 1'b0, 1'b0, -1, -1);
    chk("b2b_op2_sum", sum32(), 64'd63);

    // Reset during beat 4, then a fresh operation.
    accept32(32'd5, 32'd3, 1'b0);
    beats32('0, '0, 1'b0, 1'b0, -1, 4);
    accept32(32'd7, 32'd9, 1'b0);
    beats32('0, '0, 1'b0, 1'b0, -1, -1);
    chk("after_rst_sum", sum32(), 64'd63);

    cx = $urandom; cy = $urandom; cm = 1'($urandom_range(0, 1));
    accept32(cx, cy, cm);
    for (int i = 0; i < 600; i++) begin
      nx = $urandom; ny = $urandom; nm = 1'($urandom_range(0, 1));
      if (i % 7 == 0) nx = 32'h80000000;
      if (i % 11 == 0) ny = 32'hFFFFFFFF;
      ch = (i != 599) && ($urandom_range(0, 1) == 1);
      beats32(nx, ny, nm, ch, -1, -1);
      chk("rand32_sum", sum32(), prod32(cx, cy, cm));
      if (i != 599 && !ch) accept32(nx, ny, nm);
      cx = nx; cy = ny; cm = nm;
    end

    accept8(8'h80, 8'h80, 1'b1);
    beat8('0, '0, 1'b0, 1'b0);
    chk("w8_min_sq", 64'(sum8()), 64'h4000);
    accept8(8'hFF, 8'hFF, 1'b0);
    beat8('0, '0, 1'b0, 1'b0);
    chk("w8_umax_sq", 64'(sum8()), 64'hFE01);
    accept8(8'hFF, 8'hFF, 1'b1);
    beat8('0, '0, 1'b0, 1'b0);
    chk("w8_neg1_sq", 64'(sum8()), 64'h0001);

    ax = 8'($urandom); ay = 8'($urandom); am = 1'($urandom_range(0, 1));
    accept8(ax, ay, am);
    for (int i = 0; i < 1000; i++) begin
      bx = 8'($urandom); by = 8'($urandom); bm = 1'($urandom_range(0, 1));
      ch = (i != 999) && ($urandom_range(0, 1) == 1);
      beat8(bx, by, bm, ch);
      chk("rand8_sum", 64'(sum8()), 64'(prod8(ax, ay, am)));
      if (i != 999 && !ch) accept8(bx, by, bm);
      ax = bx; ay = by; am = bm;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
